// File: rtl/packet_io.sv
// Packet buffer front-end: stores an incoming byte stream in memory, hands memory
// to a program executor, then streams the stored packet back out.
module packet_io #(
   parameter int unsigned PKT_BASE  = 128,
   parameter int unsigned CODE_ADDR = 64,
   parameter int unsigned MAX_LEN   = 64,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_last_i,
   output logic        rx_ready_o,
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_width_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   output logic        exec_start_o,
   output logic [31:0] exec_addr_o,
   input  logic        exec_done_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_last_o,
   input  logic        tx_ready_i,
   output logic        timeout_o
);

   localparam int unsigned AW  = 32;
   localparam int unsigned CW  = 16;
   localparam int unsigned WDW = 32;
   localparam logic [CW-1:0]  LAST_IDX = CW'(MAX_LEN - 1);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, RECV, DROP, EXEC, READ, SEND} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  idx_q, idx_d;
   logic [CW-1:0]  len_q, len_d;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           is_last;
   logic           rx_xfer;
   logic           mem_rdata_unused;

   assign mem_rdata_unused = ^mem_data_i[31:8];
   assign tx_data_o        = tx_data_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         wdog_q    <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         wdog_q    <= wdog_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      len_d        = len_q;
      wdog_d       = wdog_q;
      tx_data_d    = tx_data_q;
      rx_ready_o   = 1'b0;
      mem_ce_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_width_o  = 4'd0;
      mem_data_o   = '0;
      exec_start_o = 1'b0;
      exec_addr_o  = '0;
      tx_valid_o   = 1'b0;
      tx_last_o    = 1'b0;
      timeout_o    = 1'b0;
      is_last      = (idx_q == (len_q - 16'd1));
      rx_xfer      = 1'b0;

      case (state_q)
         IDLE, RECV: begin
            // Held off during reset so a byte offered in a reset cycle is never stored
            rx_ready_o = ~rst;
            rx_xfer    = rx_valid_i & ~rst;
            if (rx_xfer) begin
               mem_ce_o    = 1'b1;
               mem_we_o    = 1'b1;
               mem_width_o = 4'd1;
               mem_addr_o  = AW'(PKT_BASE) + AW'(cnt_q);
               mem_data_o  = {24'b0, rx_data_i};
               cnt_d       = cnt_q + 16'd1;
               if (rx_last_i || (cnt_q == LAST_IDX)) begin
                  len_d   = cnt_q + 16'd1;
                  wdog_d  = '0;
                  state_d = rx_last_i ? EXEC : DROP;
               end else begin
                  state_d = RECV;
               end
            end
         end
         DROP: begin
            rx_ready_o = ~rst;
            rx_xfer    = rx_valid_i & ~rst;
            if (rx_xfer && rx_last_i) begin
               wdog_d  = '0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec_start_o = 1'b1;
            exec_addr_o  = AW'(CODE_ADDR);
            if (exec_done_i) begin
               idx_d   = '0;
               state_d = READ;
            end else if (wdog_q == WD_LIMIT) begin
               timeout_o = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         READ: begin
            mem_ce_o    = 1'b1;
            mem_width_o = 4'd1;
            mem_addr_o  = AW'(PKT_BASE) + AW'(idx_q);
            tx_data_d   = mem_data_i[7:0];
            state_d     = SEND;
         end
         SEND: begin
            tx_valid_o = 1'b1;
            tx_last_o  = is_last;
            if (tx_ready_i) begin
               if (is_last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 16'd1;
                  state_d = READ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_packet_io.sv
// Directed bench for packet_io: cycle table for a full store/execute/send pass,
// plus hand sequences for overflow drop, watchdog, back-pressure and reset.
module tb_packet_io;

   logic        clk;
   logic        rst;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_last_i;
   logic        rx_ready_o;
   logic        mem_ce_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_width_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        exec_start_o;
   logic [31:0] exec_addr_o;
   logic        exec_done_i;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_last_o;
   logic        tx_ready_i;
   logic        timeout_o;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0;
   logic [7:0] mem [0:255];

   packet_io #(.PKT_BASE(128), .CODE_ADDR(64), .MAX_LEN(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_last_i(rx_last_i),
      .rx_ready_o(rx_ready_o),
      .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .exec_start_o(exec_start_o), .exec_addr_o(exec_addr_o), .exec_done_i(exec_done_i),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o),
      .tx_ready_i(tx_ready_i), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide memory model: write on the clock edge, combinational read
   always @(posedge clk) begin
      if (mem_ce_o && mem_we_o) begin
         mem[mem_addr_o[7:0]] = mem_data_o[7:0];
         wr_cnt = wr_cnt + 1;
      end
   end
   assign mem_data_i = {24'h0, mem[mem_addr_o[7:0]]};

   typedef struct packed {
      logic       vld;
      logic [7:0] dat;
      logic       lst;
      logic       done;
      logic       trdy;
      logic       rdy;
      logic       ce;
      logic       we;
      logic [31:0] addr;
      logic [7:0] wd;
      logic       st;
      logic       tv;
      logic [7:0] td;
      logic       tl;
   } vec_t;

   vec_t vt [16];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic lst, input logic wr,
                          input logic [31:0] a, input string nm);
      rx_valid_i = 1'b1;
      rx_data_i  = d;
      rx_last_i  = lst;
      #1;
      check(nm, 128'({rx_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_data_o}),
                128'({1'b1, wr, wr, wr ? a : 32'h0, wr ? {24'h0, d} : 32'h0}));
      @(negedge clk);
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      rx_last_i  = 1'b0;
   endtask

   task automatic expect_tx(input logic [7:0] d, input logic lst, input string nm);
      logic seen;
      seen = 1'b0;
      tx_ready_i = 1'b1;
      for (int k = 0; k < 8 && !seen; k++) begin
         #1;
         if (tx_valid_o) seen = 1'b1;
         else @(negedge clk);
      end
      check(nm, 128'({seen, tx_data_o, tx_last_o}), 128'({1'b1, d, lst}));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got no finish want finish");
      $fatal(1, "time limit");
   end

   initial begin
      int wr0;
      logic [127:0] act;
      logic [127:0] exp;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      //        vld  dat    lst  done trdy rdy  ce   we   addr    wd     st   tv   td     tl
      vt[0]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b0,8'h00,1'b0};
      vt[1]  = '{1'b1,8'h11,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'd128,8'h11,1'b0,1'b0,8'h00,1'b0};
      vt[2]  = '{1'b1,8'h22,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'd129,8'h22,1'b0,1'b0,8'h00,1'b0};
      vt[3]  = '{1'b1,8'h33,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'd130,8'h33,1'b0,1'b0,8'h00,1'b0};
      vt[4]  = '{1'b1,8'h44,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,32'd131,8'h44,1'b0,1'b0,8'h00,1'b0};
      vt[5]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b1,1'b0,8'h00,1'b0};
      vt[6]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b1,1'b0,8'h00,1'b0};
      vt[7]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd128,8'h00,1'b0,1'b0,8'h00,1'b0};
      vt[8]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b1,8'h11,1'b0};
      vt[9]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd129,8'h00,1'b0,1'b0,8'h11,1'b0};
      vt[10] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b1,8'h22,1'b0};
      vt[11] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd130,8'h00,1'b0,1'b0,8'h22,1'b0};
      vt[12] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b1,8'h33,1'b0};
      vt[13] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd131,8'h00,1'b0,1'b0,8'h33,1'b0};
      vt[14] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b1,8'h44,1'b1};
      vt[15] = '{1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'd0,  8'h00,1'b0,1'b0,8'h44,1'b0};

      rst = 1'b1;
      rx_valid_i = 1'b0; rx_data_i = 8'h00; rx_last_i = 1'b0;
      exec_done_i = 1'b0; tx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Store 11,22,33,44 then run and send them back
      for (int i = 0; i < 16; i++) begin
         rx_valid_i  = vt[i].vld;
         rx_data_i   = vt[i].dat;
         rx_last_i   = vt[i].lst;
         exec_done_i = vt[i].done;
         tx_ready_i  = vt[i].trdy;
         #1;
         act = 128'({rx_ready_o, mem_ce_o, mem_we_o, mem_width_o, mem_addr_o, mem_data_o,
                     exec_start_o, exec_start_o ? exec_addr_o : 32'h0,
                     tx_valid_o, tx_data_o, tx_last_o, timeout_o});
         exp = 128'({vt[i].rdy, vt[i].ce, vt[i].we, vt[i].ce ? 4'd1 : 4'd0, vt[i].addr,
                     {24'h0, vt[i].wd}, vt[i].st, vt[i].st ? 32'd64 : 32'd0,
                     vt[i].tv, vt[i].td, vt[i].tl, 1'b0});
         check($sformatf("vec%0d", i), act, exp);
         @(negedge clk);
      end
      rx_valid_i = 1'b0; exec_done_i = 1'b0; tx_ready_i = 1'b0;

      // Overflow: 6 bytes into a 4-byte buffer, the tail is dropped
      wr0 = wr_cnt;
      rx_byte(8'hA1, 1'b0, 1'b1, 32'd128, "ovf_b1");
      rx_byte(8'hA2, 1'b0, 1'b1, 32'd129, "ovf_b2");
      rx_byte(8'hA3, 1'b0, 1'b1, 32'd130, "ovf_b3");
      rx_byte(8'hA4, 1'b0, 1'b1, 32'd131, "ovf_b4");
      rx_byte(8'hA5, 1'b0, 1'b0, 32'd0,   "ovf_drop5");
      rx_byte(8'hA6, 1'b1, 1'b0, 32'd0,   "ovf_drop6");
      exec_done_i = 1'b1;
      #1;
      check("ovf_exec_first", 128'({exec_start_o, exec_addr_o}), 128'({1'b1, 32'd64}));
      @(negedge clk);
      exec_done_i = 1'b0;
      expect_tx(8'hA1, 1'b0, "ovf_tx1");
      expect_tx(8'hA2, 1'b0, "ovf_tx2");
      expect_tx(8'hA3, 1'b0, "ovf_tx3");
      expect_tx(8'hA4, 1'b1, "ovf_tx4");
      check("ovf_mem", 128'({mem[128], mem[129], mem[130], mem[131], mem[132], mem[133], 32'(wr_cnt - wr0)}),
                       128'({8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 32'd4}));
      tx_ready_i = 1'b0;

      // Watchdog expiry with done held low
      rx_byte(8'h5A, 1'b1, 1'b1, 32'd128, "wd_rx");
      for (int c = 1; c <= 16; c++) begin
         #1;
         check($sformatf("wd_cyc%0d", c), 128'({exec_start_o, timeout_o, tx_valid_o}),
                                         128'({1'b1, c == 16, 1'b0}));
         @(negedge clk);
      end
      #1;
      check("wd_after", 128'({rx_ready_o, exec_start_o, timeout_o, tx_valid_o}),
                        128'({1'b1, 1'b0, 1'b0, 1'b0}));

      // Next packet; done arrives in the limit cycle and beats the watchdog
      rx_byte(8'h6B, 1'b1, 1'b1, 32'd128, "wd_next_rx");
      for (int c = 1; c <= 15; c++) begin
         #1;
         if (timeout_o) check($sformatf("wd2_early%0d", c), 128'(timeout_o), 128'(0));
         @(negedge clk);
      end
      exec_done_i = 1'b1;
      #1;
      check("done_wins", 128'({exec_start_o, timeout_o}), 128'({1'b1, 1'b0}));
      @(negedge clk);
      exec_done_i = 1'b0;
      #1;
      check("done_wins_read", 128'({mem_ce_o, mem_we_o, mem_addr_o}), 128'({1'b1, 1'b0, 32'd128}));
      expect_tx(8'h6B, 1'b1, "done_wins_tx");
      tx_ready_i = 1'b0;

      // Back-pressure in SEND
      rx_byte(8'h77, 1'b0, 1'b1, 32'd128, "bp_rx1");
      rx_byte(8'h88, 1'b1, 1'b1, 32'd129, "bp_rx2");
      exec_done_i = 1'b1;
      @(negedge clk);
      exec_done_i = 1'b0;
      tx_ready_i  = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp_hold%0d", k), 128'({tx_valid_o, tx_data_o, tx_last_o, mem_ce_o}),
                                          128'({1'b1, 8'h77, 1'b0, 1'b0}));
         @(negedge clk);
      end
      expect_tx(8'h77, 1'b0, "bp_tx1");
      expect_tx(8'h88, 1'b1, "bp_tx2");
      tx_ready_i = 1'b0;

      // Reset lands on the third byte of a packet
      mem[130] = 8'hEE;
      rx_byte(8'h01, 1'b0, 1'b1, 32'd128, "rst_rx1");
      rx_byte(8'h02, 1'b0, 1'b1, 32'd129, "rst_rx2");
      rst        = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h03;
      #1;
      check("rst_byte_noce", 128'(mem_ce_o & mem_we_o), 128'(0));
      @(negedge clk);
      rst        = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      #1;
      check("rst_after", 128'({rx_ready_o, exec_start_o, tx_valid_o, mem[130]}),
                         128'({1'b1, 1'b0, 1'b0, 8'hEE}));
      rx_byte(8'h09, 1'b1, 1'b1, 32'd128, "rst_restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/packet_io.md
PACKET_IO -- requirements
Module: packet_io

Interface
REQ-001 Parameter PKT_BASE, default 128, SHALL be the byte address in memory where the packet is stored.
REQ-002 Parameter CODE_ADDR, default 64, SHALL be the program start address driven to the executor.
REQ-003 Parameter MAX_LEN, default 64, SHALL be the maximum stored packet length in bytes (range 1..65535).
REQ-004 Parameter TIMEOUT, default 4096, SHALL be the executor watchdog limit in cycles.
REQ-005 Ports SHALL be (name  direction  width  meaning), with `ADDR_BUS and `DATA_BUS each 32 bits:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_valid_i  in  1  input byte valid
- rx_data_i  in  8  input byte
- rx_last_i  in  1  final byte of input packet
- rx_ready_o  out  1  block accepts input byte
- mem_ce_o  out  1  memory access enable
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  `ADDR_BUS  byte address
- mem_width_o  out  4  access width in bytes
- mem_data_o  out  `DATA_BUS  write data, byte in bits [7:0]
- mem_data_i  in  `DATA_BUS  read data, byte in bits [7:0], valid in the same cycle as the read
- exec_start_o  out  1  start request to executor
- exec_addr_o  out  `ADDR_BUS  program start address
- exec_done_i  in  1  executor finished
- tx_valid_o  out  1  output byte valid
- tx_data_o  out  8  output byte
- tx_last_o  out  1  final output byte
- tx_ready_i  in  1  downstream accepts byte
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Function
REQ-006 The FSM SHALL have states IDLE, RECV, DROP, EXEC, READ, SEND.
REQ-007 rx_ready_o SHALL be 1 in IDLE, RECV and DROP, and 0 in all other states; a byte transfers when rx_valid_i && rx_ready_o.
REQ-008 In IDLE/RECV, each transfer SHALL drive mem_ce_o=1, mem_we_o=1, mem_width_o=4'd1, mem_addr_o=PKT_BASE+cnt, mem_data_o={24'b0, rx_data_i} combinationally, and increment cnt.
- First transfer in IDLE moves to RECV with cnt=0 used for that byte.
REQ-009 A transfer with rx_last_i=1, or the transfer storing byte index MAX_LEN-1, SHALL latch len=cnt+1 and move to EXEC next cycle.
REQ-010 If byte MAX_LEN-1 is not last, the FSM SHALL enter DROP, accepting and discarding bytes without memory access until a transfer with rx_last_i=1, then enter EXEC with len=MAX_LEN.
REQ-011 In EXEC, exec_start_o SHALL be 1 and exec_addr_o SHALL equal CODE_ADDR; all mem_* outputs SHALL be 0 so the executor owns memory.
REQ-012 exec_done_i SHALL be sampled every EXEC cycle, including the first; on 1, exec_start_o drops next cycle, idx=0 and the FSM moves to READ.
REQ-013 A watchdog SHALL count EXEC cycles from 0; if it reaches TIMEOUT-1 without exec_done_i, timeout_o SHALL pulse for one cycle and the FSM SHALL return to IDLE without transmitting; done in that same cycle wins.
REQ-014 In READ, the block SHALL drive mem_ce_o=1, mem_we_o=0, mem_width_o=4'd1, mem_addr_o=PKT_BASE+idx, register mem_data_i[7:0] into tx_data_o, and move to SEND.
REQ-015 In SEND, tx_valid_o SHALL be 1, tx_last_o SHALL be (idx==len-1), and tx_data_o SHALL be stable until tx_ready_i=1.
- On handshake: if last, go to IDLE; else increment idx and go to READ.
REQ-016 Outside the stated cases, mem_ce_o, mem_we_o, tx_valid_o and exec_start_o SHALL be 0; mem_addr_o, mem_data_o and mem_width_o SHALL be 0.
REQ-017 cnt, idx and len SHALL be 16 bits; addresses SHALL be PKT_BASE plus the zero-extended index, modulo 2^32.

Reset
REQ-018 While rst=1 at a clock edge, the FSM SHALL go to IDLE and clear cnt, idx, len, the watchdog and tx_data_o; all outputs take their idle values in the following cycle, from any state including mid-packet.

Verification
REQ-019 Receive 4 bytes 11,22,33,44 (last on 44) -> writes at 128..131; exec_start_o=1 with exec_addr_o=64.
REQ-020 From the REQ-019 state, pulse exec_done_i -> tx bytes 11,22,33,44 with tx_last_o on 44; 2 cycles per byte with tx_ready_i=1; back to IDLE.
REQ-021 MAX_LEN=4, send 6 bytes, last on the 6th -> only 4 bytes written at 128..131; bytes 5 and 6 accepted and dropped; 4 bytes transmitted.
REQ-022 TIMEOUT=16, exec_done_i held 0 -> timeout_o high exactly in the 16th EXEC cycle; no tx_valid_o; next packet accepted normally.
REQ-023 tx_ready_i=0 for 5 cycles in SEND -> tx_data_o and tx_last_o held constant; no memory read issued.
REQ-024 Assert rst during the 3rd rx byte -> that byte is not written, and the next cycle rx_ready_o=1 in IDLE and exec_start_o=0.
